// File: rtl/sub_a_rle_pkg.sv
// sub_a_rle_pkg: shared types, widths and helpers for the sub_a run-length
// capture stage.
// Optional feature macro: SUB_A_RLE_PARITY_EN. When it is defined, each record
// carries an extra top bit holding even parity over the rest of the record.
package sub_a_rle_pkg;

    // Width of the sampled sub_a output vector {testo1_a, testo2_a, testo1_sub_a}.
    localparam int VEC_W = 3;

    // Capture FSM states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Record width for a given run-length counter width.
    function automatic int rec_w(input int cnt_w);
`ifdef SUB_A_RLE_PARITY_EN
        return VEC_W + cnt_w + 1;
`else
        return VEC_W + cnt_w;
`endif
    endfunction

    // Even-parity bit over a record body. The body is zero-extended by the
    // caller, so the padding bits do not change the result.
    function automatic logic rec_parity(input logic [63:0] body);
        return ^body;
    endfunction

endpackage

// File: rtl/sub_a_rle_fifo.sv
// sub_a_rle_fifo: small synchronous FIFO for capture records.
// Pointers carry one extra wrap bit: equal pointers mean empty, pointers that
// differ only in the wrap bit mean full. The caller decides whether a push is
// allowed; this block writes whenever push is asserted.
module sub_a_rle_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    // Advance the write pointer on push and the read pointer on a valid pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (pop && !empty) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Record storage; cleared on reset so the head reads zero while empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= push_data;
        end
    end

    assign pop_data = r_mem[r_rd_ptr[AW-1:0]];
    assign empty    = (r_wr_ptr == r_rd_ptr);
    assign full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/sub_a_rle_capture.sv
// sub_a_rle_capture: run-length capture of the three sub_a outputs.
// Each enabled cycle samples {testo1_a, testo2_a, testo1_sub_a}; whenever the
// value changes (or capture is disabled mid-run) one record {value, run_length}
// is queued in a FIFO and drained through a valid/ready port.
// Optional feature macro: SUB_A_RLE_PARITY_EN (even-parity bit on top of each
// record, computed when the record is pushed).
//
// Output handshake: a record moves when out_valid && out_ready at a rising clk
// edge. out_valid never depends on out_ready, and out_valid/out_data hold
// steady until the head record is accepted.
module sub_a_rle_capture
    import sub_a_rle_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     testo1_a,
    input  logic                     testo2_a,
    input  logic                     testo1_sub_a,
    input  logic                     clr_ovf,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [rec_w(CNT_W)-1:0]  out_data,
    output logic                     overflow,
    output state_e                   dbg_state
);

    localparam int               REC_W   = rec_w(CNT_W);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Sampling stage: enable and vector are registered together so the FSM
    // always sees a matching pair.
    logic [VEC_W-1:0] r_cur;
    logic             r_en;

    // Run tracking.
    state_e           r_state;
    logic [VEC_W-1:0] r_prev_vec;
    logic [CNT_W-1:0] r_run_cnt;

    logic             r_overflow;

    logic                     w_push_req;
    logic                     w_push_ok;
    logic                     w_pop;
    logic                     w_full;
    logic                     w_empty;
    logic [VEC_W+CNT_W-1:0]   w_body;
    logic [REC_W-1:0]         w_push_data;

    // Register the same-domain sub_a outputs and the enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cur <= '0;
            r_en  <= 1'b0;
        end else begin
            r_cur <= {testo1_a, testo2_a, testo1_sub_a};
            r_en  <= enable;
        end
    end

    // A run ends when the sampled value changes or capture is switched off.
    assign w_push_req = (r_state == ST_RUN) && (!r_en || (r_cur != r_prev_vec));
    assign w_pop      = out_valid && out_ready;
    // A full FIFO still takes a record when the head leaves on the same edge.
    assign w_push_ok  = w_push_req && (!w_full || w_pop);

    assign w_body = {r_prev_vec, r_run_cnt};
`ifdef SUB_A_RLE_PARITY_EN
    assign w_push_data = {rec_parity(64'(w_body)), w_body};
`else
    assign w_push_data = w_body;
`endif

    // Capture FSM: start a run, extend it (saturating), or close it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_prev_vec <= '0;
            r_run_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_en) begin
                        r_prev_vec <= r_cur;
                        r_run_cnt  <= CNT_ONE;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!r_en) begin
                        r_state <= ST_IDLE;
                    end else if (r_cur != r_prev_vec) begin
                        r_prev_vec <= r_cur;
                        r_run_cnt  <= CNT_ONE;
                    end else if (r_run_cnt != CNT_MAX) begin
                        r_run_cnt <= r_run_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else if (w_push_req && !w_push_ok) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    sub_a_rle_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_push_ok),
        .push_data (w_push_data),
        .pop       (w_pop),
        .pop_data  (out_data),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign out_valid = !w_empty;
    assign overflow  = r_overflow;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_sub_a_rle_capture.sv
// tb_sub_a_rle_capture: directed scenarios plus a randomized run checked
// against a queue-based reference model of the capture stage.
module tb_sub_a_rle_capture;
  import sub_a_rle_pkg::*;

  localparam int CNT_W = 8;
  localparam int DEPTH = 4;
  localparam int REC_W = rec_w(CNT_W);
  localparam int MAXC  = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic             enable = 1'b0;
  logic [2:0]       vec = 3'b000;
  logic             clr_ovf = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [REC_W-1:0] out_data;
  logic             overflow;
  state_e           dbg_state;

  sub_a_rle_capture #(
    .CNT_W      (CNT_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .testo1_a     (vec[2]),
    .testo2_a     (vec[1]),
    .testo1_sub_a (vec[0]),
    .clr_ovf      (clr_ovf),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .overflow     (overflow),
    .dbg_state    (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Build an expected record from an 11-bit {value, length} body.
  function automatic logic [REC_W-1:0] add_par(input logic [10:0] b);
`ifdef SUB_A_RLE_PARITY_EN
    return {^b, b};
`else
    return b;
`endif
  endfunction

  function automatic logic [REC_W-1:0] mk_rec(input logic [2:0] v, input int len);
    int l;
    l = (len > MAXC) ? MAXC : len;
    return add_par({v, 8'(l)});
  endfunction

  // ---------------- reference model / scoreboard ----------------
  // Samples seen at one edge are judged at the next edge (the capture
  // register), and a finished run lands in the FIFO on that same edge.
  logic [REC_W-1:0] exp_q[$];
  logic [2:0]       run_q[$];
  logic             m_s_en;
  logic [2:0]       m_s_vec;
  bit               m_ovf;
  bit               m_push, m_pop, m_drop;
  int               m_sz;
  logic [REC_W-1:0] m_rec;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q.delete();
      run_q.delete();
      m_s_en  = 1'b0;
      m_s_vec = 3'b000;
      m_ovf   = 1'b0;
    end else begin
      m_push = 1'b0;
      m_drop = 1'b0;
      if (m_s_en) begin
        if (run_q.size() != 0 && m_s_vec != run_q[0]) begin
          m_push = 1'b1;
          m_rec  = mk_rec(run_q[0], run_q.size());
          run_q.delete();
        end
        run_q.push_back(m_s_vec);
      end else if (run_q.size() != 0) begin
        m_push = 1'b1;
        m_rec  = mk_rec(run_q[0], run_q.size());
        run_q.delete();
      end
      m_sz  = exp_q.size();
      m_pop = (m_sz != 0) && out_ready;
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) begin
        if (m_sz < DEPTH || m_pop) exp_q.push_back(m_rec);
        else m_drop = 1'b1;
      end
      if (m_drop) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
      m_s_en  = enable;
      m_s_vec = vec;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    enable    = 1'b0;
    clr_ovf   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    vec = 3'b111;
    do_reset();
    n_tests++;
    if (out_data !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h want 0", out_data);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      n_tests++;
      if (out_valid !== 1'b0 || overflow !== 1'b0 || dbg_state !== ST_IDLE) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: valid=%b ovf=%b state=%0d want 0 0 0",
                 i, out_valid, overflow, dbg_state);
      end
    end
  endtask

  task automatic test_single_run();
    do_reset();
    enable = 1'b1;
    vec = 3'b101;
    repeat (5) tick();
    vec = 3'b011;
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_early: valid=%b want 0", out_valid);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== add_par(11'h505)) begin
      n_fail++;
      $display("FAIL single_rec: valid=%b data=%h want 1 %h", out_valid, out_data, add_par(11'h505));
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== add_par(11'h505)) begin
      n_fail++;
      $display("FAIL single_hold: valid=%b data=%h want 1 %h", out_valid, out_data, add_par(11'h505));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_pop: valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_saturate();
    bit got;
    do_reset();
    enable = 1'b1;
    vec = 3'b001;
    repeat (300) tick();
    vec = 3'b010;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      tick();
      got = out_valid;
    end
    n_tests++;
    if (!got || out_data !== add_par(11'h1FF)) begin
      n_fail++;
      $display("FAIL saturate: valid=%b data=%h want 1 %h", got, out_data, add_par(11'h1FF));
    end
  endtask

  task automatic test_overflow();
    logic [10:0] exp_list[4];
    exp_list = '{11'h002, 11'h101, 11'h201, 11'h301};
    do_reset();
    enable = 1'b1;
    vec = 3'b000;
    repeat (2) tick();
    for (int v = 1; v <= 6; v++) begin
      vec = 3'(v);
      tick();
    end
    repeat (3) tick();
    n_tests++;
    if (overflow !== 1'b1 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set: ovf=%b valid=%b want 1 1", overflow, out_valid);
    end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    n_tests++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clear: ovf=%b want 0", overflow);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== add_par(exp_list[i])) begin
        n_fail++;
        $display("FAIL ovf_drain %0d: valid=%b data=%h want 1 %h", i, out_valid, out_data,
                 add_par(exp_list[i]));
      end
      tick();
    end
    out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL ovf_empty: valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_enable_off();
    do_reset();
    enable = 1'b1;
    vec = 3'b110;
    repeat (3) tick();
    enable = 1'b0;
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL en_off_early: valid=%b want 0", out_valid);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== add_par(11'h603) || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL en_off_rec: valid=%b data=%h state=%0d want 1 %h 0", out_valid, out_data,
               dbg_state, add_par(11'h603));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    enable = 1'b1;
    vec = 3'b010;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL reen_quiet %0d: valid=%b want 0", i, out_valid);
      end
    end
    n_tests++;
    if (dbg_state !== ST_RUN) begin
      n_fail++; $display("FAIL reen_state: state=%0d want 1", dbg_state);
    end
    vec = 3'b111;
    tick();
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== add_par(11'h206)) begin
      n_fail++;
      $display("FAIL reen_rec: valid=%b data=%h want 1 %h", out_valid, out_data, add_par(11'h206));
    end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    enable = 1'b1;
    vec = 3'b000; tick();
    vec = 3'b001; tick();
    vec = 3'b010; tick();
    repeat (2) tick();
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL midrun_queued: valid=%b want 1", out_valid);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrun_async: valid=%b want 0", out_valid);
    end
    enable = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if (out_valid !== 1'b0 || dbg_state !== ST_IDLE || overflow !== 1'b0) begin
        n_fail++;
        $display("FAIL midrun_after %0d: valid=%b state=%0d ovf=%b want 0 0 0", i, out_valid,
                 dbg_state, overflow);
      end
    end
  endtask

  task automatic test_random();
    int run_left;
    int errs;
    run_left = 0;
    errs = 0;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if (run_left == 0) begin
        vec = 3'($urandom_range(0, 7));
        run_left = $urandom_range(1, 6);
      end
      run_left--;
      enable = ($urandom_range(0, 11) != 0);
      if (((i / 150) % 2) == 1) out_ready = ($urandom_range(0, 9) < 3);
      else out_ready = ($urandom_range(0, 9) < 8);
      clr_ovf = ($urandom_range(0, 25) == 0);
      tick();
      n_tests++;
      if (out_valid !== (exp_q.size() != 0) ||
          (exp_q.size() != 0 && out_data !== exp_q[0]) ||
          overflow !== m_ovf ||
          dbg_state !== ((run_q.size() != 0) ? ST_RUN : ST_IDLE)) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random cyc %0d: valid=%b data=%h ovf=%b state=%0d want %b %h %b %0d",
                   i, out_valid, out_data, overflow, dbg_state, exp_q.size() != 0,
                   (exp_q.size() != 0) ? exp_q[0] : '0, m_ovf, run_q.size() != 0);
      end
    end
    enable = 1'b0;
    clr_ovf = 1'b0;
    out_ready = 1'b0;
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_single_run();
    test_saturate();
    test_overflow();
    test_enable_off();
    test_reset_midrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
